// File: rtl/framebuf_rd_if.sv
// BRAM read port plus output-FIFO write port of the frame-buffer read engine.
interface framebuf_rd_if #(
  parameter int AW     = 19,
  parameter int DATA_W = 12,
  parameter int FILL_W = 12
);
  logic [AW-1:0]     o_raddr;
  logic              o_rd_en;
  logic [DATA_W-1:0] i_rdata;
  logic              o_wr;
  logic [DATA_W:0]   o_wdata;
  logic [FILL_W-1:0] i_fill;

  modport master (
    output o_raddr, o_rd_en, o_wr, o_wdata,
    input  i_rdata, i_fill
  );

  modport slave (
    input  o_raddr, o_rd_en, o_wr, o_wdata,
    output i_rdata, i_fill
  );
endinterface

// File: rtl/framebuf_rd.sv
// Streams frame-buffer pixels into the display FIFO, sof-tagging address 0; read-to-write latency RD_LATENCY+1.
// Backpressure: reads issue only while FIFO fill plus reads in flight stays below FIFO_THRESH.
module framebuf_rd #(
  parameter int FRAME_W     = 640,
  parameter int FRAME_H     = 480,
  parameter int BRAM_DEPTH  = 307200,
  parameter int DATA_W      = 12,
  parameter int RD_LATENCY  = 2,
  parameter int FILL_W      = 12,
  parameter int FIFO_THRESH = 2044
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_en,
  input  logic          i_sync,
  framebuf_rd_if.master bus,
  output logic          o_frame_done,
  output logic          o_busy
);
  localparam int AW = $clog2(BRAM_DEPTH);
  localparam int PW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int RW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
  localparam int IW = $clog2(RD_LATENCY + 2);

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2} state_t;

  state_t                state, state_nxt;
  logic [AW-1:0]         addr;
  logic [PW-1:0]         pix;
  logic [RW-1:0]         row;
  logic [IW-1:0]         inflight;
  logic [RD_LATENCY-1:0] vld_pipe;
  logic [RD_LATENCY-1:0] sof_pipe;
  logic [FILL_W:0]       occ;
  logic                  room;
  logic                  drained;
  logic                  issue;
  logic                  clr;

  // The decision is made one cycle before o_rd_en shows it, so the read on o_rd_en counts as in flight.
  assign occ     = {1'b0, bus.i_fill} + (FILL_W+1)'(inflight) + (FILL_W+1)'(bus.o_rd_en);
  assign room    = occ < (FILL_W+1)'(FIFO_THRESH);
  assign drained = (inflight == '0) && !bus.o_rd_en;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_en) state_nxt = ACTIVE;
      ACTIVE:  if (i_sync || !i_en) state_nxt = DRAIN;
      DRAIN:   if (drained) state_nxt = i_en ? ACTIVE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue = 1'b0;
    clr   = 1'b0;
    case (state)
      ACTIVE:  issue = i_en && !i_sync && room;
      default: clr   = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      addr         <= '0;
      pix          <= '0;
      row          <= '0;
      inflight     <= '0;
      vld_pipe     <= '0;
      sof_pipe     <= '0;
      bus.o_raddr  <= '0;
      bus.o_rd_en  <= 1'b0;
      bus.o_wr     <= 1'b0;
      bus.o_wdata  <= '0;
      o_frame_done <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      bus.o_rd_en  <= issue;
      o_frame_done <= issue && (pix == PW'(FRAME_W-1)) && (row == RW'(FRAME_H-1));
      o_busy       <= (state_nxt != IDLE);
      if (issue) bus.o_raddr <= addr;

      // Outside ACTIVE the position is held at the frame origin so every restart begins a new frame.
      if (clr) begin
        addr <= '0;
        pix  <= '0;
        row  <= '0;
      end else if (issue) begin
        addr <= (addr == AW'(BRAM_DEPTH-1)) ? '0 : addr + AW'(1);
        if (pix == PW'(FRAME_W-1)) begin
          pix <= '0;
          row <= (row == RW'(FRAME_H-1)) ? '0 : row + RW'(1);
        end else begin
          pix <= pix + PW'(1);
        end
      end

      vld_pipe[0] <= bus.o_rd_en;
      sof_pipe[0] <= bus.o_rd_en && (bus.o_raddr == '0);
      for (int k = 1; k < RD_LATENCY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        sof_pipe[k] <= sof_pipe[k-1];
      end
      bus.o_wr    <= vld_pipe[RD_LATENCY-1];
      bus.o_wdata <= vld_pipe[RD_LATENCY-1] ? {sof_pipe[RD_LATENCY-1], bus.i_rdata} : '0;

      case ({bus.o_rd_en, bus.o_wr})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
    end
  end
endmodule

// File: tb/tb_framebuf_rd.sv
// Bench for framebuf_rd on a 4x3 frame: BRAM model, address/data scoreboard, directed backpressure/sync/reset steps.
module tb_framebuf_rd;
  localparam int W      = 4;
  localparam int H      = 3;
  localparam int D      = 12;
  localparam int L      = 2;
  localparam int THRESH = 2044;

  logic clk = 1'b0;
  logic rstn;
  logic en;
  logic sync;
  logic frame_done;
  logic busy;

  framebuf_rd_if #(.AW(4), .DATA_W(12), .FILL_W(12)) bus ();

  framebuf_rd #(
    .FRAME_W(W), .FRAME_H(H), .BRAM_DEPTH(D), .DATA_W(12),
    .RD_LATENCY(L), .FILL_W(12), .FIFO_THRESH(THRESH)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_sync(sync),
    .bus(bus), .o_frame_done(frame_done), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_rd     = 0;
  int n_wr     = 0;
  int exp_addr = 0;
  int mon_c;
  logic [12:0] mon_e;
  bit mon_on      = 1'b0;
  bit single_mode = 1'b0;
  logic [12:0] exp_q[$];
  int          cyc_q[$];
  logic [3:0]  a1;

  function automatic logic [11:0] memf(input int a);
    return 12'((a * 291 + 7) ^ 32'h5A5);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // BRAM with two cycles from registered address to data
  always @(posedge clk) begin
    a1          <= bus.o_raddr;
    bus.i_rdata <= memf(int'(a1));
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_on) begin
      chk("frame_done", 32'(frame_done), 32'(bus.o_rd_en && (exp_addr == D-1)));
      if (bus.o_wr) begin
        n_wr++;
        chk("wr_has_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          mon_c = cyc_q.pop_front();
          chk("wdata", 32'(bus.o_wdata), 32'(mon_e));
          chk("wr_latency", cyc, mon_c + L + 1);
        end
      end
      if (bus.o_rd_en) begin
        if (single_mode) chk("one_outstanding", exp_q.size(), 0);
        chk("raddr", 32'(bus.o_raddr), exp_addr);
        exp_q.push_back({exp_addr == 0, memf(exp_addr)});
        cyc_q.push_back(cyc);
        n_rd++;
        exp_addr = (exp_addr + 1) % D;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_issue(input int a, input string tag);
    int k = 0;
    bit found = 1'b0;
    while (!found && k < 200) begin
      step(1);
      k++;
      found = (bus.o_rd_en === 1'b1) && (int'(bus.o_raddr) == a);
    end
    chk(tag, 32'(found), 32'(1));
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 50) begin
      step(1);
      k++;
    end
    chk(tag, 32'(busy), 32'(0));
  endtask

  initial begin
    int r;
    rstn = 1'b0;
    en   = 1'b0;
    sync = 1'b0;
    bus.i_fill = '0;
    step(3);
    chk("rst_raddr", 32'(bus.o_raddr), 0);
    chk("rst_rd_en", 32'(bus.o_rd_en), 0);
    chk("rst_wr", 32'(bus.o_wr), 0);
    chk("rst_wdata", 32'(bus.o_wdata), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_busy", 32'(busy), 0);
    mon_on = 1'b1;
    rstn = 1'b1;
    step(2);
    chk("idle_no_read", 32'(bus.o_rd_en), 0);

    // startup and continuous run across two frame wraps
    en = 1'b1;
    wait_issue(0, "first_issue");
    chk("busy_active", 32'(busy), 1);
    step(30);

    // backpressure at, just below, and well below threshold
    bus.i_fill = 12'(THRESH);
    step(8);
    chk("drained_at_thresh", exp_q.size(), 0);
    r = n_rd;
    step(20);
    chk("no_issue_at_thresh", n_rd - r, 0);
    bus.i_fill = 12'(THRESH - 1);
    single_mode = 1'b1;
    r = n_rd;
    step(25);
    chk("progress_below_thresh", 32'((n_rd - r) >= 3), 32'(1));
    single_mode = 1'b0;
    bus.i_fill = '0;
    step(2);
    r = n_rd;
    step(10);
    chk("b2b_resume", n_rd - r, 10);

    // sync mid-frame
    wait_issue(5, "reach_5");
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    chk("no_issue_after_sync", 32'(bus.o_rd_en), 0);
    exp_addr = 0;
    wait_issue(0, "restart_after_sync");
    chk("drained_before_restart", exp_q.size(), 0);

    // disable mid-frame
    wait_issue(7, "reach_7");
    en = 1'b0;
    step(1);
    chk("no_issue_after_disable", 32'(bus.o_rd_en), 0);
    wait_idle("idle_after_drain");
    chk("drain_writes_done", exp_q.size(), 0);
    r = n_rd;
    step(5);
    chk("idle_no_issue", n_rd - r, 0);

    // reset with three reads in flight
    exp_addr = 0;
    en = 1'b1;
    wait_issue(2, "reach_2");
    rstn = 1'b0;
    en   = 1'b0;
    step(1);
    chk("inrst_raddr", 32'(bus.o_raddr), 0);
    chk("inrst_rd_en", 32'(bus.o_rd_en), 0);
    chk("inrst_wr", 32'(bus.o_wr), 0);
    chk("inrst_wdata", 32'(bus.o_wdata), 0);
    chk("inrst_frame_done", 32'(frame_done), 0);
    chk("inrst_busy", 32'(busy), 0);
    exp_q.delete();
    cyc_q.delete();
    r = n_wr;
    step(1);
    rstn = 1'b1;
    step(8);
    chk("no_wr_after_reset", n_wr - r, 0);

    // sync colliding with the last-address issue slot
    exp_addr = 0;
    en = 1'b1;
    wait_issue(10, "reach_10");
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    chk("no_addr11_after_sync", 32'(bus.o_rd_en), 0);
    chk("no_frame_done_collision", 32'(frame_done), 0);
    exp_addr = 0;
    wait_issue(0, "restart_after_collision");
    chk("collision_drained", exp_q.size(), 0);
    step(6);
    en = 1'b0;
    wait_idle("final_idle");
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
